// File: rtl/max7219_pkg.sv
// Shared constants, state types and helpers for the MAX7219 display driver.
// Register addresses follow the MAX7219 map; digit k lives at address k.
package max7219_pkg;

    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    typedef enum logic [3:0] {
        SEQ_INIT0,
        SEQ_INIT1,
        SEQ_INIT2,
        SEQ_INIT3,
        SEQ_INIT4,
        SEQ_DIGIT1,
        SEQ_DIGIT2,
        SEQ_DIGIT3,
        SEQ_DIGIT4,
        SEQ_DIGIT5,
        SEQ_DIGIT6,
        SEQ_DIGIT7,
        SEQ_DIGIT8,
        SEQ_SHIFT,
        SEQ_GAP
    } seq_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SHIFT,
        TX_GAP
    } tx_state_e;

    // Segment order D7..D0 = DP,A,B,C,D,E,F,G; DP is never lit.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'h7E;
            4'h1: seg = 8'h30;
            4'h2: seg = 8'h6D;
            4'h3: seg = 8'h79;
            4'h4: seg = 8'h33;
            4'h5: seg = 8'h5B;
            4'h6: seg = 8'h5F;
            4'h7: seg = 8'h70;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h7B;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h1F;
            4'hC: seg = 8'h4E;
            4'hD: seg = 8'h3D;
            4'hE: seg = 8'h4F;
            default: seg = 8'h47;
        endcase
        return seg;
    endfunction

    function automatic logic [15:0] pack_word(input logic [3:0] addr, input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

endpackage

// File: rtl/max7219_shift_tx.sv
// Generic MSB-first serial shifter with LOAD/CS framing and an idle gap.
// busy stays high from the accepted start through the 2*HALF cs-high gap.
module max7219_shift_tx
    import max7219_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int HALF  = 4
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             busy_o,
    output logic             gap_last_o,
    output logic             spi_clk_o,
    output logic             dout_o,
    output logic             cs_o,
    output logic             stop_o
);

    localparam int CW = $clog2(2 * HALF) + 1;
    localparam int BW = $clog2(WIDTH + 1);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    half_q, half_d;
    logic [CW-1:0]    gap_q, gap_d;
    logic             spi_clk_q, spi_clk_d;
    logic             dout_q, dout_d;
    logic             cs_q, cs_d;
    logic             stop_q, stop_d;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            shreg_q   <= '0;
            bit_q     <= '0;
            half_q    <= '0;
            gap_q     <= '0;
            spi_clk_q <= 1'b0;
            dout_q    <= 1'b0;
            cs_q      <= 1'b1;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_q     <= bit_d;
            half_q    <= half_d;
            gap_q     <= gap_d;
            spi_clk_q <= spi_clk_d;
            dout_q    <= dout_d;
            cs_q      <= cs_d;
            stop_q    <= stop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_d     = bit_q;
        half_d    = half_q;
        gap_d     = gap_q;
        spi_clk_d = spi_clk_q;
        dout_d    = dout_q;
        cs_d      = cs_q;
        stop_d    = stop_q;
        case (state_q)
            TX_IDLE: begin
                // stop holds through the idle cycle so the gap reads a full 2*HALF.
                if (start_i) begin
                    state_d   = TX_SHIFT;
                    shreg_d   = data_i;
                    dout_d    = data_i[WIDTH-1];
                    cs_d      = 1'b0;
                    spi_clk_d = 1'b0;
                    stop_d    = 1'b0;
                    half_d    = CW'(HALF - 1);
                    bit_d     = BW'(WIDTH - 1);
                end
            end
            TX_SHIFT: begin
                if (half_q == '0) begin
                    half_d = CW'(HALF - 1);
                    if (!spi_clk_q) begin
                        spi_clk_d = 1'b1;
                    end else begin
                        spi_clk_d = 1'b0;
                        if (bit_q == '0) begin
                            state_d = TX_GAP;
                            cs_d    = 1'b1;
                            dout_d  = 1'b0;
                            stop_d  = 1'b1;
                            gap_d   = CW'(2 * HALF - 2);
                        end else begin
                            bit_d   = bit_q - 1'b1;
                            shreg_d = shreg_q << 1;
                            dout_d  = shreg_q[WIDTH-2];
                        end
                    end
                end else begin
                    half_d = half_q - 1'b1;
                end
            end
            TX_GAP: begin
                if (gap_q == '0) begin
                    state_d = TX_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign busy_o     = (state_q != TX_IDLE);
    assign gap_last_o = (state_q == TX_GAP) && (gap_q == '0);
    assign spi_clk_o  = spi_clk_q;
    assign dout_o     = dout_q;
    assign cs_o       = cs_q;
    assign stop_o     = stop_q;

endmodule

// File: rtl/max7219_display.sv
// Debug hex display over a MAX7219 daisy chain: init once, then refresh digits forever.
// Define MAX7219_PERIODIC_REINIT_EN to resend the init block after every refresh pass.
//
// state       | meaning
// ------------+--------------------------------------------------
// SEQ_INIT0   | send test-mode off (0x0F00)
// SEQ_INIT1   | send scan limit = 8 digits (0x0B07)
// SEQ_INIT2   | send no-decode (0x0900)
// SEQ_INIT3   | send intensity (0x0A0n)
// SEQ_INIT4   | send normal operation (0x0C01)
// SEQ_DIGITk  | send digit k from the frame, k = 1..8
// SEQ_SHIFT   | words shifting out, cs low
// SEQ_GAP     | cs high idle gap before the next step
module max7219_display
    import max7219_pkg::*;
#(
    parameter int NUM_CASCADES    = 2,
    parameter int INTENSITY       = 1,
    parameter int SPI_HALF_PERIOD = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [7:0]  frame [4*NUM_CASCADES],
    output logic        spi_clk,
    output logic        dout,
    output logic        cs,
    output logic        stop,
    output logic [10:1] pin
);

    localparam int         WIDTH = 16 * NUM_CASCADES;
    localparam int         FW    = $clog2(4 * NUM_CASCADES);
    localparam logic [3:0] INTENSITY_NIB = 4'(INTENSITY);

    seq_state_e       state_q, state_d;
    seq_state_e       after_q, after_d;
    logic             run_q;
    logic             tx_start;
    logic             tx_busy;
    logic             tx_gap_last;
    logic [WIDTH-1:0] tx_data;
    logic [15:0]      init_word;
    logic [3:0]       digit_addr;
    logic             is_digit;
    logic [1:0]       byte_sel;
    logic [FW-1:0]    byte_idx;
    logic [7:0]       sel_byte;

    function automatic seq_state_e next_step(input seq_state_e cur);
        seq_state_e nxt;
        if (cur == SEQ_DIGIT8) begin
`ifdef MAX7219_PERIODIC_REINIT_EN
            nxt = SEQ_INIT0;
`else
            nxt = SEQ_DIGIT1;
`endif
        end else begin
            nxt = seq_state_e'(4'(cur) + 4'd1);
        end
        return nxt;
    endfunction

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= SEQ_INIT0;
            after_q <= SEQ_INIT1;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            after_q <= after_d;
            run_q   <= 1'b1;
        end
    end

    // Step states launch their word the moment the shifter is free, so the
    // shifter's gap alone sets the spacing between transactions.
    always_comb begin
        state_d  = state_q;
        after_d  = after_q;
        tx_start = 1'b0;
        case (state_q)
            SEQ_SHIFT: begin
                if (tx_gap_last) begin
                    state_d = after_q;
                end else if (stop) begin
                    state_d = SEQ_GAP;
                end
            end
            SEQ_GAP: begin
                if (tx_gap_last) begin
                    state_d = after_q;
                end
            end
            default: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = SEQ_SHIFT;
                    after_d  = next_step(state_q);
                end
            end
        endcase
    end

    always_comb begin
        init_word  = '0;
        digit_addr = '0;
        is_digit   = 1'b0;
        case (state_q)
            SEQ_INIT0:  init_word = pack_word(ADDR_TEST, 8'h00);
            SEQ_INIT1:  init_word = pack_word(ADDR_SCANLIMIT, 8'h07);
            SEQ_INIT2:  init_word = pack_word(ADDR_DECODE, 8'h00);
            SEQ_INIT3:  init_word = pack_word(ADDR_INTENSITY, {4'h0, INTENSITY_NIB});
            SEQ_INIT4:  init_word = pack_word(ADDR_SHUTDOWN, 8'h01);
            SEQ_DIGIT1: begin is_digit = 1'b1; digit_addr = ADDR_DIGIT0; end
            SEQ_DIGIT2: begin is_digit = 1'b1; digit_addr = ADDR_DIGIT1; end
            SEQ_DIGIT3: begin is_digit = 1'b1; digit_addr = ADDR_DIGIT2; end
            SEQ_DIGIT4: begin is_digit = 1'b1; digit_addr = ADDR_DIGIT3; end
            SEQ_DIGIT5: begin is_digit = 1'b1; digit_addr = ADDR_DIGIT4; end
            SEQ_DIGIT6: begin is_digit = 1'b1; digit_addr = ADDR_DIGIT5; end
            SEQ_DIGIT7: begin is_digit = 1'b1; digit_addr = ADDR_DIGIT6; end
            SEQ_DIGIT8: begin is_digit = 1'b1; digit_addr = ADDR_DIGIT7; end
            default: ;
        endcase
    end

    // Digit k takes byte (8-k)/2 of its device: digit 8 (leftmost) is byte 0's high nibble.
    assign byte_sel = 2'((4'd8 - digit_addr) >> 1);

    always_comb begin
        tx_data  = '0;
        byte_idx = '0;
        sel_byte = '0;
        for (int c = 0; c < NUM_CASCADES; c++) begin
            byte_idx = FW'(4 * c + int'(byte_sel));
            sel_byte = frame[byte_idx];
            if (is_digit) begin
                tx_data[16*c +: 16] = pack_word(digit_addr,
                    hex_to_seg(digit_addr[0] ? sel_byte[3:0] : sel_byte[7:4]));
            end else begin
                tx_data[16*c +: 16] = init_word;
            end
        end
    end

    max7219_shift_tx #(
        .WIDTH (WIDTH),
        .HALF  (SPI_HALF_PERIOD)
    ) u_shift_tx (
        .sysclk     (sysclk),
        .reset      (reset),
        .start_i    (tx_start),
        .data_i     (tx_data),
        .busy_o     (tx_busy),
        .gap_last_o (tx_gap_last),
        .spi_clk_o  (spi_clk),
        .dout_o     (dout),
        .cs_o       (cs),
        .stop_o     (stop)
    );

    assign pin = run_q ? {6'b0, stop, cs, dout, spi_clk} : '0;

endmodule

// File: tb/tb_max7219_display.sv
// Directed bench for max7219_display (NUM_CASCADES=2, SPI_HALF_PERIOD=4).
module tb_max7219_display;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b1;
    logic [7:0]  frame [8];
    logic        spi_clk, dout, cs, stop;
    logic [10:1] pin;

    int n_checks = 0;
    int n_errors = 0;

    max7219_display #(
        .NUM_CASCADES    (2),
        .INTENSITY       (1),
        .SPI_HALF_PERIOD (4)
    ) dut (
        .sysclk  (sysclk),
        .reset   (reset),
        .frame   (frame),
        .spi_clk (spi_clk),
        .dout    (dout),
        .cs      (cs),
        .stop    (stop),
        .pin     (pin)
    );

    always #5 sysclk = ~sysclk;

    // After init: INIT1..INIT4 then digits 1..8 for the frame loaded below.
    logic [31:0] exp_seq [12] = '{
        32'h0B070B07, 32'h09000900, 32'h0A010A01, 32'h0C010C01,
        32'h017E0147, 32'h024E027E, 32'h037E037E, 32'h047E047E,
        32'h057E057E, 32'h067E067E, 32'h071F076D, 32'h08770830
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered on a negedge; returns on the negedge where the next cs-low is first seen.
    task automatic get_tx(input string tag, input logic [31:0] exp_word, input bit timing);
        logic [31:0] w = '0;
        logic        prev = 1'b0;
        int          low = 0, gap = 0, stop_n = 0, lim = 0;
        bit          to = 1'b0;
        while (cs !== 1'b0 && lim < 2000) begin @(negedge sysclk); lim++; end
        if (lim >= 2000) to = 1'b1;
        lim = 0;
        while (cs === 1'b0 && lim < 2000) begin
            low++;
            if (spi_clk === 1'b1 && prev === 1'b0) w = {w[30:0], dout};
            prev = spi_clk;
            @(negedge sysclk);
            lim++;
        end
        if (lim >= 2000) to = 1'b1;
        lim = 0;
        while (cs === 1'b1 && lim < 2000) begin
            if (timing && gap == 0)
                check({tag, "_pin_gap"}, 32'({pin[10:5], pin[4:3], pin[1]}), 32'h006);
            gap++;
            if (stop === 1'b1) stop_n++;
            @(negedge sysclk);
            lim++;
        end
        if (lim >= 2000) to = 1'b1;
        check({tag, "_timeout"}, 32'(to), 32'd0);
        check(tag, w, exp_word);
        if (timing) begin
            check({tag, "_cs_low_cycles"}, 32'(low), 32'd256);
            check({tag, "_gap_cycles"}, 32'(gap), 32'd8);
            check({tag, "_stop_cycles"}, 32'(stop_n), 32'd8);
        end
    endtask

    initial begin
        int lim;
        for (int i = 0; i < 8; i++) frame[i] = 8'h00;
        frame[0] = 8'h12;
        frame[4] = 8'hAB;
        frame[3] = 8'h0F;
        frame[7] = 8'hC0;

        repeat (3) @(negedge sysclk);
        check("rst_spi_clk", 32'(spi_clk), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_stop", 32'(stop), 32'd0);
        check("rst_pin", 32'(pin), 32'd0);

        reset = 1'b0;
        @(negedge sysclk);
        check("first_cs_fall", 32'(cs), 32'd0);
        get_tx("init0", 32'h0F000F00, 1'b1);

        for (int i = 0; i < 12; i++)
            get_tx($sformatf("seq%0d", i + 1), exp_seq[i], 1'b0);

`ifdef MAX7219_PERIODIC_REINIT_EN
        get_tx("wrap_reinit", 32'h0F000F00, 1'b0);
        for (int i = 0; i < 5; i++)
            get_tx($sformatf("pass2_seq%0d", i + 1), exp_seq[i], 1'b0);
`else
        get_tx("wrap_digit1", 32'h017E0147, 1'b0);
`endif

        // Frame changes while digit 2 is shifting must only show from digit 3 on.
        fork
            get_tx("d2_mid_change", 32'h024E027E, 1'b0);
            begin
                repeat (100) @(negedge sysclk);
                frame[7] = 8'h50;
                frame[6] = 8'h34;
            end
        join
        get_tx("d3_new_frame", 32'h0333037E, 1'b0);

        // Abort digit 4 while spi_clk is high.
        repeat (20) @(negedge sysclk);
        lim = 0;
        while (!(spi_clk === 1'b1 && cs === 1'b0) && lim < 500) begin
            @(negedge sysclk);
            lim++;
        end
        check("mid_find_timeout", 32'(lim >= 500), 32'd0);
        check("mid_pin_shift", 32'({pin[3], pin[1]}), 32'h1);
        reset = 1'b1;
        @(negedge sysclk);
        check("mid_rst_cs", 32'(cs), 32'd1);
        check("mid_rst_spi_clk", 32'(spi_clk), 32'd0);
        check("mid_rst_stop", 32'(stop), 32'd0);
        check("mid_rst_pin", 32'(pin), 32'd0);
        reset = 1'b0;
        @(negedge sysclk);
        check("restart_cs_fall", 32'(cs), 32'd0);
        get_tx("reinit0", 32'h0F000F00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/max7219_display.md
Name: max7219_display

Overview:
- Drives a daisy chain of NUM_CASCADES MAX7219 8-digit 7-segment controllers over a 3-wire serial link (spi_clk/dout/cs).
- Each device shows four frame bytes as eight hex digits.
- Runs continuously from sysclk, independent of the CPU clock, and serves as a debug display of bus address, instruction, registers and flags.
- After reset it configures all devices, then refreshes digits 1..8 endlessly from a live frame input.

Parameters:
- NUM_CASCADES, 2, number of chained MAX7219 devices; frame has 4*NUM_CASCADES bytes.
- INTENSITY, 1, 4-bit brightness written to register 0x0A (0..15).
- SPI_HALF_PERIOD, 4, sysclk cycles per spi_clk half period (>=1).

Ports:
- sysclk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock sysclk.
- frame  in  8 x (4*NUM_CASCADES)  unpacked byte array; bytes 4c..4c+3 belong to device c.
- spi_clk  out  1  serial clock to MAX7219 CLK.
- dout  out  1  serial data to MAX7219 DIN, MSB first.
- cs  out  1  MAX7219 LOAD/CS, active-low frame, latch on rising edge.
- stop  out  1  high while idle between transactions (cs-high gap).
- pin  out  10 (10:1)  debug: pin[1]=spi_clk, pin[2]=dout, pin[3]=cs, pin[4]=stop, pin[10:5]=0.

Behaviour:
- Reset (sync): spi_clk=0, dout=0, cs=1, stop=0, pin=0. Any transaction in flight is aborted and the sequencer restarts at init step 0. Output is registered; the first transaction starts the cycle after reset deasserts.
- Word format: 16 bits = {4'h0, addr[3:0], data[7:0]}. A transaction shifts NUM_CASCADES words (16*NUM_CASCADES bits).
  - The word for device NUM_CASCADES-1 is shifted first; the word for device 0 is shifted last.
  - Device 0 is the device wired to dout.
- Bit timing, H = SPI_HALF_PERIOD:
  - cs falls and dout presents the MSB in the same cycle.
  - spi_clk rises H cycles later and falls H cycles after that; the next bit is presented on that falling edge.
  - After the last falling edge, cs rises in the same cycle with spi_clk=0.
  - cs stays high (stop=1) for 2H cycles before the next transaction.
  - Transaction length is 32*NUM_CASCADES*H + 2H cycles.
- Sequencer states: INIT0..INIT4, DIGIT1..DIGIT8, SHIFT, GAP.
  - INIT words, sent identically to all devices, in order: 0x0F00 (test off), 0x0B07 (scan 8 digits), 0x0900 (no decode), 0x0A00|INTENSITY, 0x0C01 (normal operation).
  - DIGITk uses addr = k, k = 1..8. After DIGIT8 the sequencer returns to DIGIT1 forever.
- Digit mapping for device c, digit k: byte = frame[4c + (8-k)/2]; k even uses the high nibble, k odd the low nibble. Digit 8 is the leftmost digit.
- Frame bytes are sampled when the transaction starts (cs fall). Changes during a shift do not affect that transaction.
- Segment font (no-decode, D7=DP..D0=G, DP always 0):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
- INTENSITY is truncated to 4 bits.

Optional Feature:
- Macro MAX7219_PERIODIC_REINIT_EN.
  - Defined: after DIGIT8 the sequencer goes to INIT0 instead of DIGIT1, so the full config is re-sent every refresh pass. This recovers devices that glitch or power up late.
  - Undefined: the init sequence is sent once per reset only.

Decomposition:
- Package max7219_pkg holds:
  - register address constants (DIGIT0..7, DECODE=9, INTENSITY=A, SCANLIMIT=B, SHUTDOWN=C, TEST=F);
  - the hex-to-segment font function;
  - the word-packing function {4'h0, addr, data}.
- Sub-module max7219_shift_tx: generic N-bit MSB-first shifter with cs/spi_clk timing and start/busy handshake.
  - start is accepted only when not busy.
  - busy covers the shift plus the 2H gap.
- The top-level block contains the sequencer and digit mapping only.

Test Plan:
- Reset, NUM_CASCADES=2, H=4: first captured 32 bits = 0x0F000F00. cs is low for exactly 256 cycles. Next cs fall occurs 8 cycles after cs rise.
- Continue capturing transactions: 0x0B070B07, 0x09000900, 0x0A010A01, 0x0C010C01, then digit address 1.
- Set frame[0]=0x12, frame[4]=0xAB, capture the digit-8 transaction -> 0x08770830. Digit 7 -> 0x071F086D is wrong; the required value is 0x071F076D.
- Set frame[3]=0x0F, frame[7]=0xC0, capture digit 1 -> 0x017E0147. Capture digit 2 -> 0x024E027E.
- Change frame mid-transaction -> the current words are unchanged; the next transaction reflects the new value.
- Assert reset mid-shift -> cs=1, spi_clk=0 next cycle. After release, 0x0F000F00 is sent again. With MAX7219_PERIODIC_REINIT_EN defined, 0x0F000F00 also follows digit 8.
